debug_run_ctl: RTL and testbench
================================

Name: debug_run_ctl

Overview:
- Run/halt sequencer for the RV core. Sits between the debug module's hart-control signals and the core's control FSM.
- Decides at instruction boundaries whether the core fetches the next instruction or enters debug mode. Tells the core when to save pc to dpc and when to restore it.
- Handles halt, resume, single-step, ebreak-to-debug, trigger and reset-halt requests, and produces the per-hart status bits for dmstatus.

Parameters:
- CauseWidth, 3: width of dcsr.cause encoding.
- StepMaskInt, 1: when 1, step_mask is asserted while stepping so interrupts are masked.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- haltreq  in  1  DM halt request, level
- resumereq  in  1  DM resume request, level; only its rising edge acts
- resethaltreq  in  1  halt-on-reset request, sampled in the first cycle after reset
- ackhavereset  in  1  clears havereset
- dcsr_step  in  1  dcsr.step
- dcsr_ebreakm  in  1  dcsr.ebreakm
- inst_boundary  in  1  core is in fetch state and about to fetch; pc holds the next instruction address
- retire  in  1  instruction completed (pc write), includes traps
- ebreak  in  1  core is executing ebreak this cycle
- trigger_hit  in  1  address trigger matched pc at the boundary
- core_halt  out  1  hold core in fetch state; block write_ir and write_pc
- inhibit_trap  out  1  suppress the breakpoint exception and pc write for the current ebreak
- dpc_write  out  1  capture current pc into dpc
- cause  out  CauseWidth  dcsr.cause value, valid with dpc_write
- exit_debug  out  1  one-cycle pulse: load pc from dpc
- step_mask  out  1  mask interrupts during a step
- debug_mode, halted, running, resumeack, havereset  out  1 each  status bits

Behaviour:
- **States:** INIT, RUN, HALTED, RESUME, STEP.
- **Reset values:** state=INIT, havereset=1, resumeack=0. All pulse outputs are 0; core_halt=1; cause=0.
- **INIT (1 cycle):**
  - If resethaltreq: latch pending cause 5.
  - Go to RUN.
- **RUN:**
  - core_halt=0, running=1.
  - haltreq sets a sticky halt_pend latch.
- **Halt decision** (RUN or STEP, when inst_boundary=1), first match wins:
  - cause 5 (reset pend)
  - cause 2 (trigger_hit)
  - cause 1 (ebreak pend)
  - cause 3 (halt_pend or haltreq)
  - cause 4 (STEP with step_done)
- **On a halt decision, in the same cycle:**
  - core_halt=1 combinationally, so no fetch starts.
  - dpc_write=1 with the cause; the exception is cause 1, where dpc was already written (see ebreak below).
  - Next state HALTED; clear all pend latches and step_done.
- **ebreak:** with ebreak=1, dcsr_ebreakm=1 and state RUN/STEP:
  - Same cycle: inhibit_trap=1 and dpc_write=1 (pc still equals the ebreak address).
  - Latch ebreak pend.
  - Halt occurs at the next inst_boundary.
  - With dcsr_ebreakm=0 the block stays passive.
- **HALTED:**
  - core_halt=1, halted=1, debug_mode=1.
  - Rising edge of resumereq with haltreq=0: resumeack←0, go to RESUME.
  - A resumereq edge while haltreq=1 is ignored.
- **RESUME (1 cycle):**
  - exit_debug=1, core_halt=1, resumeack←1.
  - Next state is STEP if dcsr_step, else RUN.
- **STEP:**
  - core_halt=0; step_mask=StepMaskInt.
  - The first retire sets step_done; a trap retire counts as the step.
  - haltreq while stepping halts with cause 3 (priority above cause 4).
- **resumeack:** stays 1 until the next accepted resume edge.
- **havereset:** cleared by ackhavereset; set only by rst.
- **Simultaneous events:**
  - ebreak and retire in the same cycle in STEP: ebreak pend wins (cause 1).
  - rst mid-operation returns to INIT regardless of state.
- **Edge detector:** the resumereq edge detector register resets to 1, so a resumereq held through reset is not treated as an edge.

Decomposition:
- Shared package debug_pkg holds:
  - the state enum;
  - cause constants: CAUSE_EBREAK=1, TRIGGER=2, HALTREQ=3, STEP=4, RESETHALT=5.
  Both the dcsr CSR logic and this block use them.
- No sub-module; the cause priority encoder is an always_comb inside the block.

Test Plan:
- After rst with resethaltreq=1, first inst_boundary → dpc_write=1, cause=5, halted=1 the next cycle; havereset=1 until ackhavereset.
- In RUN, pulse haltreq 1 cycle with no boundary, then inst_boundary 3 cycles later → halt on that boundary with cause=3 and core_halt=1 in the same cycle.
- Halted, dcsr_step=1, resumereq rise:
  - expect exit_debug for 1 cycle, resumeack=1, step_mask=1;
  - retire, then the next boundary → halt with cause=4.
- ebreak with dcsr_ebreakm=1 → inhibit_trap=1 and dpc_write=1 in the same cycle; halt at the next boundary with cause=1.
- ebreak with dcsr_ebreakm=0 → inhibit_trap=0 and no halt.
- trigger_hit and haltreq at the same boundary → cause=2.
- resumereq rise while haltreq=1 → stays HALTED, resumeack unchanged.
- rst asserted in STEP → INIT next cycle, core_halt=1, resumeack=0.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared debug definitions: run/halt sequencer states and dcsr.cause encodings.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_HALTED = 3'd2,
    ST_RESUME = 3'd3,
    ST_STEP   = 3'd4
  } dbg_state_e;

  localparam int unsigned CAUSE_EBREAK    = 1;
  localparam int unsigned CAUSE_TRIGGER   = 2;
  localparam int unsigned CAUSE_HALTREQ   = 3;
  localparam int unsigned CAUSE_STEP      = 4;
  localparam int unsigned CAUSE_RESETHALT = 5;

endpackage

// File: rtl/debug_run_ctl.sv
// Run/halt sequencer between the debug module hart controls and the core control FSM.
// Decides at each instruction boundary whether the core fetches or enters debug mode.
//
// state  | meaning
// INIT   | first cycle after reset, samples resethaltreq
// RUN    | core executing normally
// HALTED | core parked in debug mode
// RESUME | one-cycle pc<-dpc restore
// STEP   | executing a single instruction, then halts
module debug_run_ctl
  import debug_pkg::*;
#(
  parameter int unsigned CauseWidth  = 3,
  parameter bit          StepMaskInt = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  haltreq_i,
  input  logic                  resumereq_i,
  input  logic                  resethaltreq_i,
  input  logic                  ackhavereset_i,
  input  logic                  dcsr_step_i,
  input  logic                  dcsr_ebreakm_i,
  input  logic                  inst_boundary_i,
  input  logic                  retire_i,
  input  logic                  ebreak_i,
  input  logic                  trigger_hit_i,
  output logic                  core_halt_o,
  output logic                  inhibit_trap_o,
  output logic                  dpc_write_o,
  output logic [CauseWidth-1:0] cause_o,
  output logic                  exit_debug_o,
  output logic                  step_mask_o,
  output logic                  debug_mode_o,
  output logic                  halted_o,
  output logic                  running_o,
  output logic                  resumeack_o,
  output logic                  havereset_o
);

  dbg_state_e state_q, state_d;
  logic halt_pend_q, halt_pend_d;
  logic ebreak_pend_q, ebreak_pend_d;
  logic reset_pend_q, reset_pend_d;
  logic step_done_q, step_done_d;
  logic resumeack_q, resumeack_d;
  logic havereset_q, havereset_d;
  logic resumereq_q;

  logic                  active;
  logic                  resume_rise;
  logic                  halt_now;
  logic [CauseWidth-1:0] halt_cause;

  assign active      = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign resume_rise = resumereq_i & ~resumereq_q;

  // Halt cause priority encoder; first match wins.
  always_comb begin
    halt_now   = 1'b0;
    halt_cause = '0;
    if (active && inst_boundary_i) begin
      halt_now = 1'b1;
      if (reset_pend_q)                          halt_cause = CauseWidth'(CAUSE_RESETHALT);
      else if (trigger_hit_i)                    halt_cause = CauseWidth'(CAUSE_TRIGGER);
      else if (ebreak_pend_q)                    halt_cause = CauseWidth'(CAUSE_EBREAK);
      else if (halt_pend_q || haltreq_i)         halt_cause = CauseWidth'(CAUSE_HALTREQ);
      else if (state_q == ST_STEP && step_done_q) halt_cause = CauseWidth'(CAUSE_STEP);
      else                                       halt_now   = 1'b0;
    end
  end

  always_comb begin
    state_d        = state_q;
    halt_pend_d    = halt_pend_q;
    ebreak_pend_d  = ebreak_pend_q;
    reset_pend_d   = reset_pend_q;
    step_done_d    = step_done_q;
    resumeack_d    = resumeack_q;
    havereset_d    = havereset_q & ~ackhavereset_i;
    core_halt_o    = 1'b1;
    inhibit_trap_o = 1'b0;
    dpc_write_o    = 1'b0;
    cause_o        = '0;
    exit_debug_o   = 1'b0;
    step_mask_o    = 1'b0;
    debug_mode_o   = 1'b0;
    halted_o       = 1'b0;
    running_o      = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (resethaltreq_i) reset_pend_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        core_halt_o = 1'b0;
        running_o   = 1'b1;
      end
      ST_STEP: begin
        core_halt_o = 1'b0;
        running_o   = 1'b1;
        step_mask_o = StepMaskInt;
        if (retire_i) step_done_d = 1'b1;
      end
      ST_HALTED: begin
        halted_o     = 1'b1;
        debug_mode_o = 1'b1;
        if (resume_rise && !haltreq_i) begin
          resumeack_d = 1'b0;
          state_d     = ST_RESUME;
        end
      end
      ST_RESUME: begin
        exit_debug_o = 1'b1;
        debug_mode_o = 1'b1;
        resumeack_d  = 1'b1;
        state_d      = dcsr_step_i ? ST_STEP : ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase

    if (active) begin
      if (haltreq_i) halt_pend_d = 1'b1;
      // pc still points at the ebreak here, so dpc is captured now rather than at the boundary.
      if (ebreak_i && dcsr_ebreakm_i) begin
        inhibit_trap_o = 1'b1;
        dpc_write_o    = 1'b1;
        cause_o        = CauseWidth'(CAUSE_EBREAK);
        ebreak_pend_d  = 1'b1;
      end
    end

    if (halt_now) begin
      core_halt_o   = 1'b1;
      dpc_write_o   = (halt_cause != CauseWidth'(CAUSE_EBREAK));
      cause_o       = halt_cause;
      state_d       = ST_HALTED;
      halt_pend_d   = 1'b0;
      ebreak_pend_d = 1'b0;
      reset_pend_d  = 1'b0;
      step_done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_INIT;
      halt_pend_q   <= 1'b0;
      ebreak_pend_q <= 1'b0;
      reset_pend_q  <= 1'b0;
      step_done_q   <= 1'b0;
      resumeack_q   <= 1'b0;
      havereset_q   <= 1'b1;
      resumereq_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      halt_pend_q   <= halt_pend_d;
      ebreak_pend_q <= ebreak_pend_d;
      reset_pend_q  <= reset_pend_d;
      step_done_q   <= step_done_d;
      resumeack_q   <= resumeack_d;
      havereset_q   <= havereset_d;
      resumereq_q   <= resumereq_i;
    end
  end

  assign resumeack_o = resumeack_q;
  assign havereset_o = havereset_q;

endmodule

// File: tb/tb_debug_run_ctl.sv
// Directed bench for debug_run_ctl: halt causes, resume/step handshake, ebreak and reset behaviour.
module tb_debug_run_ctl;
  logic       clk_i = 1'b0;
  logic       rst_i, haltreq_i, resumereq_i, resethaltreq_i, ackhavereset_i;
  logic       dcsr_step_i, dcsr_ebreakm_i, inst_boundary_i, retire_i, ebreak_i, trigger_hit_i;
  logic       core_halt_o, inhibit_trap_o, dpc_write_o, exit_debug_o, step_mask_o;
  logic       debug_mode_o, halted_o, running_o, resumeack_o, havereset_o;
  logic [2:0] cause_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  debug_run_ctl #(.CauseWidth(3), .StepMaskInt(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .haltreq_i(haltreq_i), .resumereq_i(resumereq_i),
    .resethaltreq_i(resethaltreq_i), .ackhavereset_i(ackhavereset_i),
    .dcsr_step_i(dcsr_step_i), .dcsr_ebreakm_i(dcsr_ebreakm_i),
    .inst_boundary_i(inst_boundary_i), .retire_i(retire_i), .ebreak_i(ebreak_i),
    .trigger_hit_i(trigger_hit_i), .core_halt_o(core_halt_o), .inhibit_trap_o(inhibit_trap_o),
    .dpc_write_o(dpc_write_o), .cause_o(cause_o), .exit_debug_o(exit_debug_o),
    .step_mask_o(step_mask_o), .debug_mode_o(debug_mode_o), .halted_o(halted_o),
    .running_o(running_o), .resumeack_o(resumeack_o), .havereset_o(havereset_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic resume_to_run_state();
    resumereq_i = 1'b1;
    tick();
    tick();
    resumereq_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; haltreq_i = 1'b0; resumereq_i = 1'b0; resethaltreq_i = 1'b1;
    ackhavereset_i = 1'b0; dcsr_step_i = 1'b0; dcsr_ebreakm_i = 1'b0;
    inst_boundary_i = 1'b0; retire_i = 1'b0; ebreak_i = 1'b0; trigger_hit_i = 1'b0;
    tick();
    tick();
    chk("rst_core_halt", core_halt_o, 1);
    chk("rst_havereset", havereset_o, 1);
    chk("rst_resumeack", resumeack_o, 0);
    chk("rst_cause", cause_o, 0);
    chk("rst_dpc_write", dpc_write_o, 0);
    chk("rst_running", running_o, 0);

    // Reset-halt: INIT samples resethaltreq, halt at first boundary with cause 5.
    rst_i = 1'b0;
    tick();
    resethaltreq_i = 1'b0;
    chk("init_to_run", running_o, 1);
    inst_boundary_i = 1'b1;
    #1;
    chk("rh_dpc_write", dpc_write_o, 1);
    chk("rh_cause", cause_o, 5);
    chk("rh_core_halt", core_halt_o, 1);
    tick();
    inst_boundary_i = 1'b0;
    chk("rh_halted", halted_o, 1);
    chk("rh_debug_mode", debug_mode_o, 1);
    chk("rh_havereset_held", havereset_o, 1);
    ackhavereset_i = 1'b1;
    tick();
    ackhavereset_i = 1'b0;
    chk("ack_havereset", havereset_o, 0);

    resumereq_i = 1'b1;
    tick();
    chk("res_exit_debug", exit_debug_o, 1);
    chk("res_ack_low", resumeack_o, 0);
    tick();
    resumereq_i = 1'b0;
    chk("res_exit_pulse", exit_debug_o, 0);
    chk("res_ack_high", resumeack_o, 1);
    chk("res_running", running_o, 1);

    // haltreq pulse without boundary is remembered.
    haltreq_i = 1'b1;
    tick();
    haltreq_i = 1'b0;
    tick();
    tick();
    chk("hp_no_halt_yet", core_halt_o, 0);
    inst_boundary_i = 1'b1;
    #1;
    chk("hp_core_halt", core_halt_o, 1);
    chk("hp_dpc_write", dpc_write_o, 1);
    chk("hp_cause", cause_o, 3);
    tick();
    inst_boundary_i = 1'b0;
    chk("hp_halted", halted_o, 1);

    // Single step.
    dcsr_step_i = 1'b1;
    resumereq_i = 1'b1;
    tick();
    chk("st_exit_debug", exit_debug_o, 1);
    tick();
    resumereq_i = 1'b0;
    chk("st_resumeack", resumeack_o, 1);
    chk("st_step_mask", step_mask_o, 1);
    chk("st_core_run", core_halt_o, 0);
    inst_boundary_i = 1'b1;
    #1;
    chk("st_no_halt_before_retire", dpc_write_o, 0);
    inst_boundary_i = 1'b0;
    retire_i = 1'b1;
    tick();
    retire_i = 1'b0;
    inst_boundary_i = 1'b1;
    #1;
    chk("st_dpc_write", dpc_write_o, 1);
    chk("st_cause", cause_o, 4);
    tick();
    inst_boundary_i = 1'b0;
    dcsr_step_i = 1'b0;
    chk("st_halted", halted_o, 1);

    // Resume edge while haltreq is held is ignored.
    haltreq_i = 1'b1;
    resumereq_i = 1'b1;
    tick();
    chk("rh1_halted", halted_o, 1);
    chk("rh1_exit_debug", exit_debug_o, 0);
    chk("rh1_resumeack", resumeack_o, 1);
    haltreq_i = 1'b0;
    tick();
    chk("rh1_no_late_edge", halted_o, 1);
    resumereq_i = 1'b0;
    tick();
    resume_to_run_state();
    chk("rh1_back_running", running_o, 1);

    // ebreak with ebreakm set.
    dcsr_ebreakm_i = 1'b1;
    ebreak_i = 1'b1;
    #1;
    chk("eb_inhibit", inhibit_trap_o, 1);
    chk("eb_dpc_write", dpc_write_o, 1);
    chk("eb_cause", cause_o, 1);
    tick();
    ebreak_i = 1'b0;
    chk("eb_still_running", core_halt_o, 0);
    inst_boundary_i = 1'b1;
    #1;
    chk("eb_bnd_core_halt", core_halt_o, 1);
    chk("eb_bnd_no_dpc", dpc_write_o, 0);
    chk("eb_bnd_cause", cause_o, 1);
    tick();
    inst_boundary_i = 1'b0;
    chk("eb_halted", halted_o, 1);
    resume_to_run_state();

    // ebreak with ebreakm clear stays passive.
    dcsr_ebreakm_i = 1'b0;
    ebreak_i = 1'b1;
    #1;
    chk("ebm0_inhibit", inhibit_trap_o, 0);
    chk("ebm0_dpc_write", dpc_write_o, 0);
    tick();
    ebreak_i = 1'b0;
    inst_boundary_i = 1'b1;
    #1;
    chk("ebm0_no_halt", core_halt_o, 0);
    tick();
    inst_boundary_i = 1'b0;
    chk("ebm0_running", running_o, 1);

    // Trigger outranks haltreq.
    trigger_hit_i = 1'b1;
    haltreq_i = 1'b1;
    inst_boundary_i = 1'b1;
    #1;
    chk("trg_cause", cause_o, 2);
    chk("trg_dpc_write", dpc_write_o, 1);
    tick();
    trigger_hit_i = 1'b0;
    haltreq_i = 1'b0;
    inst_boundary_i = 1'b0;
    chk("trg_halted", halted_o, 1);
    tick();

    // ebreak and retire together while stepping: cause 1.
    dcsr_step_i = 1'b1;
    dcsr_ebreakm_i = 1'b1;
    resume_to_run_state();
    chk("se_step_mask", step_mask_o, 1);
    ebreak_i = 1'b1;
    retire_i = 1'b1;
    tick();
    ebreak_i = 1'b0;
    retire_i = 1'b0;
    inst_boundary_i = 1'b1;
    #1;
    chk("se_cause", cause_o, 1);
    tick();
    inst_boundary_i = 1'b0;
    tick();

    // Reset while stepping.
    resume_to_run_state();
    chk("rs_in_step", step_mask_o, 1);
    rst_i = 1'b1;
    tick();
    chk("rs_core_halt", core_halt_o, 1);
    chk("rs_resumeack", resumeack_o, 0);
    chk("rs_step_mask", step_mask_o, 0);
    chk("rs_havereset", havereset_o, 1);
    rst_i = 1'b0;
    tick();
    chk("rs_run_after_init", running_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
